// File: rtl/perf_counter_bank_if.sv
// perf_counter_bank_if
//   Read port between the control/status register slave (master side) and
//   the performance counter bank (slave side).
//
//   Parameters:
//     WIDTH - counter / read data width
//     SEL_W - channel select width
//
//   Signals:
//     rd_req_i   - single-cycle read request
//     rd_sel_i   - channel to read, sampled with rd_req_i
//     rd_clr_i   - clear-on-read qualifier, sampled with rd_req_i
//     rd_valid_o - one-cycle pulse, read result valid
//     rd_data_o  - counter value returned by the read
//     rd_ovf_o   - overflow flag of the channel that was read
`timescale 1ns/1ps

interface perf_counter_bank_if #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 2
) ();

  logic             rd_req_i;
  logic [SEL_W-1:0] rd_sel_i;
  logic             rd_clr_i;
  logic             rd_valid_o;
  logic [WIDTH-1:0] rd_data_o;
  logic             rd_ovf_o;

  modport master (
    output rd_req_i, rd_sel_i, rd_clr_i,
    input  rd_valid_o, rd_data_o, rd_ovf_o
  );

  modport slave (
    input  rd_req_i, rd_sel_i, rd_clr_i,
    output rd_valid_o, rd_data_o, rd_ovf_o
  );

endinterface

// File: rtl/perf_counter_bank.sv
// perf_counter_bank
//   NUM_CH independent event counters, each advanced by a multi-bit
//   increment per cycle. One channel at a time is read through a registered
//   read port (perf_counter_bank_if), optionally clearing it. Each channel
//   has a sticky overflow flag; a masked OR of the flags drives irq_o.
//
//   Configuration macro: PERF_CNT_SAT_EN
//     undefined - counters wrap modulo 2^WIDTH (default)
//     defined   - counters saturate at all-ones on carry out
//
//   Ports:
//     clk        - clock, rising edge
//     reset_n    - asynchronous active-low reset
//     freeze_i   - hold all counters and flags (reads still work)
//     evt_en_i   - per-channel count enable
//     evt_inc_i  - per-channel increment, channel k at [k*INC_W +: INC_W]
//     irq_en_i   - per-channel interrupt mask
//     ovf_o      - sticky per-channel overflow flags
//     irq_o      - registered OR of (ovf_o & irq_en_i)
//     rd         - read port, slave modport
`timescale 1ns/1ps

module perf_counter_bank #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 16,
  parameter int INC_W  = 2,
  parameter int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    freeze_i,
  input  logic [NUM_CH-1:0]       evt_en_i,
  input  logic [NUM_CH*INC_W-1:0] evt_inc_i,
  input  logic [NUM_CH-1:0]       irq_en_i,
  output logic [NUM_CH-1:0]       ovf_o,
  output logic                    irq_o,
  perf_counter_bank_if.slave      rd
);

  logic [NUM_CH-1:0][WIDTH-1:0] cnt_q;
  logic [NUM_CH-1:0][WIDTH-1:0] cnt_d;
  logic [NUM_CH-1:0]            ovf_q;
  logic [NUM_CH-1:0]            ovf_d;
  logic [NUM_CH-1:0][WIDTH:0]   inc;
  logic [NUM_CH-1:0][WIDTH:0]   sum;
  logic [NUM_CH-1:0]            clr_hit;

  logic [WIDTH-1:0]             rd_cnt_mux;
  logic                         rd_ovf_mux;

  logic                         rd_valid_q;
  logic [WIDTH-1:0]             rd_data_q;
  logic                         rd_ovf_q;
  logic                         irq_q;

  always_comb begin
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    inc        = '0;
    sum        = '0;
    clr_hit    = '0;
    rd_cnt_mux = '0;
    rd_ovf_mux = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (evt_en_i[k] && !freeze_i) begin
        inc[k] = (WIDTH+1)'(evt_inc_i[k*INC_W +: INC_W]);
      end
      sum[k] = {1'b0, cnt_q[k]} + inc[k];

      // An out-of-range select matches no channel, so the mux returns 0
      // and no channel is cleared.
      if (rd.rd_sel_i == SEL_W'(k)) begin
        rd_cnt_mux = cnt_q[k];
        rd_ovf_mux = ovf_q[k];
        clr_hit[k] = rd.rd_req_i && rd.rd_clr_i;
      end

      if (clr_hit[k]) begin
        // Keep the event of the read cycle; INC_W < WIDTH so this cannot
        // carry, and any carry of the normal path is intentionally dropped.
        cnt_d[k] = inc[k][WIDTH-1:0];
        ovf_d[k] = 1'b0;
      end else begin
`ifdef PERF_CNT_SAT_EN
        cnt_d[k] = sum[k][WIDTH] ? {WIDTH{1'b1}} : sum[k][WIDTH-1:0];
`else
        cnt_d[k] = sum[k][WIDTH-1:0];
`endif
        ovf_d[k] = ovf_q[k] | sum[k][WIDTH];
      end
    end
  end

  // The read captures pre-update values; irq is one stage behind ovf.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      ovf_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_ovf_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      rd_valid_q <= rd.rd_req_i;
      if (rd.rd_req_i) begin
        rd_data_q <= rd_cnt_mux;
        rd_ovf_q  <= rd_ovf_mux;
      end
      irq_q      <= |(ovf_q & irq_en_i);
    end
  end

  assign ovf_o         = ovf_q;
  assign irq_o         = irq_q;
  assign rd.rd_valid_o = rd_valid_q;
  assign rd.rd_data_o  = rd_data_q;
  assign rd.rd_ovf_o   = rd_ovf_q;

endmodule

// File: doc/perf_counter_bank.md
# perf_counter_bank

Multi-channel successor to the single-channel performance counter. It keeps `NUM_CH` independent event counters, each advanced by a multi-bit increment per cycle. Software reads one channel at a time through a registered read port, with optional read-and-clear. Each channel has a sticky overflow flag, and a maskable interrupt is raised from those flags. The block sits beside the CPU trigger logic and is read by the control/status register slave.

## Interface
- `NUM_CH`, default 4: number of counter channels (1..32).
- `WIDTH`, default 16: counter width in bits (2..32).
- `INC_W`, default 2: per-channel increment width per cycle; `INC_W < WIDTH`.
- `SEL_W`, default `$clog2(NUM_CH)` (minimum 1): channel-select width.
- `clk` input 1: single clock; all logic on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `freeze_i` input 1: when 1, all counters hold; overflow flags hold.
- `evt_en_i` input NUM_CH: per-channel count enable.
- `evt_inc_i` input NUM_CH*INC_W: per-channel increment; channel k uses bits [k*INC_W +: INC_W].
- `rd_req_i` input 1: single-cycle read request.
- `rd_sel_i` input SEL_W: channel to read; sampled with `rd_req_i`.
- `rd_clr_i` input 1: clear-on-read qualifier; sampled with `rd_req_i`.
- `rd_valid_o` output 1: read data valid, one-cycle pulse.
- `rd_data_o` output WIDTH: counter value returned by the read.
- `rd_ovf_o` output 1: overflow flag of the channel that was read.
- `ovf_o` output NUM_CH: sticky per-channel overflow flags.
- `irq_en_i` input NUM_CH: interrupt mask.
- `irq_o` output 1: registered OR of (`ovf_o & irq_en_i`).

## Operation
- Per-channel effective increment: `inc_k = evt_en_i[k] & !freeze_i ? evt_inc_i[k] : 0`, zero-extended to WIDTH+1 bits.
- Normal update: `sum_k = cnt_k + inc_k`. `cnt_k <= sum_k[WIDTH-1:0]`. If `sum_k[WIDTH]` is set, `ovf_k <= 1`.
- Read: when `rd_req_i` is 1 and `rd_sel_i < NUM_CH`, the selected channel's pre-update `cnt` and `ovf` are captured into the output registers.
- Read with `rd_clr_i`=1:
  - The selected channel loads `inc_k`, so the event in the read cycle is not lost.
  - That channel's `ovf` is cleared.
  - A carry out in that same cycle is discarded; the flag still ends up 0.
- Out-of-range select (`rd_sel_i >= NUM_CH`):
  - `rd_valid_o` still pulses, with `rd_data_o`=0 and `rd_ovf_o`=0.
  - No clear is performed on any channel.
- Unselected channels update normally during a read.
- `rd_data_o` and `rd_ovf_o` hold their last value when `rd_valid_o`=0.
- Arithmetic is unsigned; counters wrap modulo 2^WIDTH unless `PERF_CNT_SAT_EN` is defined (see Configuration).

## Timing
- Reset (`reset_n`=0, asynchronous): all `cnt`=0, `ovf_o`=0, `rd_valid_o`=0, `rd_data_o`=0, `rd_ovf_o`=0, `irq_o`=0.
- Reset asserted mid-operation aborts any pending read; no `rd_valid_o` pulse follows.
- Counter update latency is 1 cycle: an event at edge N is visible in `cnt` after edge N.
- Read latency is 1 cycle: `rd_req_i` sampled at edge N gives `rd_valid_o`=1 for the cycle following edge N. The data excludes the increment sampled at edge N.
- Back-to-back reads on every cycle are supported; each read returns one result.
- `ovf_o` updates 1 cycle after the carry event.
- `irq_o` follows `ovf_o & irq_en_i` with a further 1-cycle register stage, so 2 cycles from the overflowing increment.
- `freeze_i` takes effect on the same edge it is sampled. Reads remain fully functional while frozen, including clear, which loads 0 because the increment is gated to 0.

## Configuration
- `PERF_CNT_SAT_EN` defined:
  - When `sum_k` exceeds 2^WIDTH-1, `cnt_k` saturates to all-ones and `ovf_k` is set.
  - A saturated counter stays at all-ones until cleared by a read-clear or reset.
- `PERF_CNT_SAT_EN` undefined: wrap-around behaviour as described in Operation.

## Test plan
1. Reset and basic count:
   - Stimulus: release `reset_n`; channel 0 enabled with inc=1 for 10 cycles; channel 1 enabled with inc=3 for 4 cycles; then read channel 0 and channel 1 without clear.
   - Required: `rd_data_o`=10, then 12; `ovf_o`=0.
2. Read-and-clear in an event cycle:
   - Stimulus: channel 2 counting inc=2; `rd_req_i`/`rd_clr_i` asserted with sel=2 when `cnt`=20; read channel 2 again the next cycle without clear.
   - Required: first read returns 20; second read returns 2.
3. Wrap and overflow (macro off, WIDTH=4):
   - Stimulus: channel 0 preloaded by counting to 14; then inc=3; read-clear channel 0 afterwards.
   - Required: `cnt`=1 and `ovf_o[0]`=1 after the inc=3 edge. `irq_o`=1 two cycles later with `irq_en_i[0]`=1, and stays 0 with the mask cleared. After the read-clear, `ovf_o[0]`=0.
4. Saturation (macro on, WIDTH=4):
   - Stimulus: channel 0 at 14, inc=3.
   - Required: `cnt`=15 and `ovf`=1; further increments keep it at 15.
5. Freeze and out-of-range select:
   - Stimulus: `freeze_i`=1 for 5 cycles with events active; then sel=NUM_CH with `rd_clr_i`=1.
   - Required: all counters unchanged while frozen. Out-of-range read returns `rd_valid_o`=1, data 0, and no channel is cleared.
6. Reset mid-read:
   - Stimulus: deassert `reset_n` in the cycle after `rd_req_i`.
   - Required: `rd_valid_o` stays 0; all outputs are 0.
